// File: rtl/button_step_conditioner_pkg.sv
// Shared definitions for the push-button step conditioner: FSM encoding and
// the sizing helper for its shared timer.
package button_step_conditioner_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REPEATING    = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;

    // Width able to hold the largest of the three interval counts.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit; q is the last stage.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_step_conditioner.sv
// Turns a raw bouncing push-button into clean press/release/auto-repeat pulses;
// step_pulse feeds the enable of the downstream up-counter.
module button_step_conditioner
    import button_step_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step_pulse
);

    localparam int TW = timer_width(STABLE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [TW-1:0] STABLE_T = TW'(STABLE_CYCLES);
    localparam logic [TW-1:0] HOLD_T   = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] REPEAT_T = TW'(REPEAT_CYCLES);

    logic          s;
    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next, timer_inc;
    logic          level_next, press_next, release_next, repeat_next;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_in),
        .q    (s)
    );

    // Saturating increment: a long hold must never wrap back into a false match.
    assign timer_inc = (&timer) ? timer : timer + TW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_next;
            timer         <= timer_next;
            btn_level     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            repeat_pulse  <= repeat_next;
        end
    end

    // The timer counts accepted samples, so a transition sample counts as one;
    // with STABLE_CYCLES=1 that first sample alone is enough to commit.
    always_comb begin
        state_next   = state;
        timer_next   = timer_inc;
        level_next   = btn_level;
        press_next   = 1'b0;
        release_next = 1'b0;
        repeat_next  = 1'b0;
        case (state)
            IDLE: begin
                timer_next = '0;
                if (s) begin
                    if (STABLE_CYCLES <= 1) begin
                        state_next = HELD;
                        level_next = 1'b1;
                        press_next = 1'b1;
                    end else begin
                        state_next = PRESS_WAIT;
                        timer_next = TW'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer_inc >= STABLE_T) begin
                    state_next = HELD;
                    timer_next = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end
            end
            HELD, REPEATING: begin
                if (!s) begin
                    if (STABLE_CYCLES <= 1) begin
                        state_next   = IDLE;
                        timer_next   = '0;
                        level_next   = 1'b0;
                        release_next = 1'b1;
                    end else begin
                        state_next = RELEASE_WAIT;
                        timer_next = TW'(1);
                    end
                end else if (state == HELD) begin
                    if (HOLD_CYCLES > 0 && timer_inc >= HOLD_T) begin
                        state_next  = REPEATING;
                        timer_next  = '0;
                        repeat_next = 1'b1;
                    end
                end else if (timer_inc >= REPEAT_T) begin
                    timer_next  = '0;
                    repeat_next = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high restarts the hold delay without a new press.
                if (s) begin
                    state_next = HELD;
                    timer_next = '0;
                end else if (timer_inc >= STABLE_T) begin
                    state_next   = IDLE;
                    timer_next   = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    assign step_pulse = press_pulse | repeat_pulse;

endmodule
